stopwatch_counter: RTL and testbench
====================================

# stopwatch_counter

Parametrised minutes:seconds time counter for the stopwatch datapath, replacing the fixed single-rate up-counter. Contains its own clock prescaler, counts up or down, supports synchronous clear and preset load, and either wraps or halts at the terminal count. It sits between the run/pause control logic and the display encoder, and produces per-second tick and terminal pulses for the control logic.

## Interface
- TICK_DIV, 100_000_000: clk cycles per one-second step; legal range ≥ 1.
- MIN_MAX, 59: largest minutes value; legal range 1..255.
- MIN_W, $clog2(MIN_MAX+1): minutes width; derived, not overridden.
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  reset; asynchronous, active-high.
- enable  in  1  1 = run, 0 = pause; prescaler and count hold while low.
- down  in  1  0 = count up, 1 = count down; sampled at each step.
- wrap_en  in  1  1 = wrap past the bound, 0 = halt at the bound.
- clear  in  1  synchronous clear to 0:00.
- load  in  1  synchronous preset from load_sec/load_min.
- load_sec  in  6  preset seconds.
- load_min  in  MIN_W  preset minutes.
- seconds  out  6  current seconds, 0..59.
- minutes  out  MIN_W  current minutes, 0..MIN_MAX.
- tick  out  1  one-cycle pulse on each applied step.
- terminal  out  1  one-cycle pulse when a step arrives at the terminal value.
- done  out  1  level; set when halted at the bound.

## Operation
- Reset values: seconds=0, minutes=0, prescaler=0, tick=0, terminal=0, done=0; state=RUN_IDLE.
- Priority each cycle: rst > clear > load > step.
- clear: count=0:00, prescaler=0, done=0. Tick and terminal stay low.
- load: seconds=min(load_sec,59), minutes=min(load_min,MIN_MAX), prescaler=0, done=0. Load never pulses terminal.
- Prescaler runs 0..TICK_DIV-1 while enable=1 and done=0. A step fires on the cycle where the prescaler is TICK_DIV-1; the prescaler then returns to 0. Pause keeps the prescaler value, so the partial second is preserved.
- Up step: if sec<59, sec+1. Else sec=0 and min+1. At MIN_MAX:59 the step is an overflow.
- Down step: if sec>0, sec-1. Else sec=59 and min-1. At 0:00 the step is an underflow.
- Overflow or underflow with wrap_en=1: wrap to 0:00 (up) or MIN_MAX:59 (down), with tick.
- Overflow or underflow with wrap_en=0: the step is suppressed, there is no tick, done=1, and the count holds.
- terminal fires when an applied step produces MIN_MAX:59 (up) or 0:00 (down), in either wrap mode.
- States:
  - RUN_IDLE (enable=0) ↔ RUN_COUNT (enable=1).
  - RUN_COUNT → HALTED on a suppressed step.
  - HALTED → RUN_IDLE/RUN_COUNT only on clear or load. enable and down are ignored in HALTED.
- A change of down between steps takes effect at the next step. There is no phase reset.

## Timing
- Step latency: seconds/minutes update on the edge where the prescaler equals TICK_DIV-1 and enable=1. tick and terminal are registered on the same edge, so they are high for exactly the cycle in which the new value is visible.
- With enable held high, steps occur exactly every TICK_DIV cycles. The first step after reset/clear/load comes TICK_DIV cycles after enable is high.
- TICK_DIV=1: a step every enabled cycle.
- clear/load take effect on the next edge and override a coincident step, so no tick is issued that cycle.
- rst asserted mid-count clears everything immediately. Counting resumes TICK_DIV cycles after rst falls, provided enable=1.

## Configuration
- STOPWATCH_BCD_OUT_EN defined:
  - Adds outputs sec_bcd[7:0] and min_bcd[7:0], as tens:ones BCD digits of seconds/minutes.
  - Combinational from the registered counts, so zero latency relative to seconds/minutes.
  - Requires MIN_MAX ≤ 99; elaboration error otherwise.
- Not defined: these ports and their logic are absent. All other behaviour is identical.

## Test plan
- TICK_DIV=4, MIN_MAX=9, up, wrap_en=1, enable high from reset:
  - first tick at cycle 4 with 0:01;
  - 9:59 reached after 599 steps with terminal pulse;
  - next step gives 0:00 with tick and no terminal.
- Down, wrap_en=0, load 0:03: steps give 0:02, 0:01, 0:00 (terminal pulse). Next step is suppressed: done=1, no tick, count holds 0:00. enable toggling leaves it held. load 1:00 clears done.
- Pause: enable low after 2 prescaler cycles for 50 cycles, then high → step arrives 2 cycles later (TICK_DIV-2).
- Same-cycle clear+load+step → 0:00, no tick. load with load_sec=63, load_min=12 (MIN_MAX=9) → 9:59.
- Assert rst asynchronously mid-prescale at 3:27 → outputs zero before the next clk edge. done=0, tick=0.
- With STOPWATCH_BCD_OUT_EN and count 4:37 → sec_bcd=8'h37, min_bcd=8'h04.

Source files
------------

// File: rtl/stopwatch_counter_if.sv
// ============================================================================
//  Module   : stopwatch_counter_if
//  Purpose  : Control/data bundle between the run/pause control logic, the
//             stopwatch_counter datapath and the display encoder.
//  Modports : master - control side; drives enable/down/wrap_en/clear/load and
//                      the preset, observes the count and the status pulses.
//             slave  - the counter itself.
//  Signals  : enable, down, wrap_en, clear, load, load_sec[5:0],
//             load_min[MIN_W-1:0]                         (master -> slave)
//             seconds[5:0], minutes[MIN_W-1:0], tick,
//             terminal, done                              (slave -> master)
//             sec_bcd[7:0], min_bcd[7:0]                  (slave -> master,
//                                       only with STOPWATCH_BCD_OUT_EN)
//  Config   : STOPWATCH_BCD_OUT_EN adds the BCD display outputs.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface stopwatch_counter_if #(
   parameter int MIN_W = 6
);
   logic             enable;
   logic             down;
   logic             wrap_en;
   logic             clear;
   logic             load;
   logic [5:0]       load_sec;
   logic [MIN_W-1:0] load_min;
   logic [5:0]       seconds;
   logic [MIN_W-1:0] minutes;
   logic             tick;
   logic             terminal;
   logic             done;
`ifdef STOPWATCH_BCD_OUT_EN
   logic [7:0]       sec_bcd;
   logic [7:0]       min_bcd;

   modport master (
      output enable, down, wrap_en, clear, load, load_sec, load_min,
      input  seconds, minutes, tick, terminal, done, sec_bcd, min_bcd
   );
   modport slave (
      input  enable, down, wrap_en, clear, load, load_sec, load_min,
      output seconds, minutes, tick, terminal, done, sec_bcd, min_bcd
   );
`else
   modport master (
      output enable, down, wrap_en, clear, load, load_sec, load_min,
      input  seconds, minutes, tick, terminal, done
   );
   modport slave (
      input  enable, down, wrap_en, clear, load, load_sec, load_min,
      output seconds, minutes, tick, terminal, done
   );
`endif
endinterface

`default_nettype wire

// File: rtl/stopwatch_counter.sv
// ============================================================================
//  Module   : stopwatch_counter
//  Purpose  : Minutes:seconds stopwatch counter with built-in one-second
//             prescaler. Counts up or down, synchronous clear and preset
//             load, wraps or halts at the terminal count, and emits
//             per-step tick and terminal pulses.
//  Ports    : clk  - system clock, rising edge
//             rst  - asynchronous active-high reset
//             bus  - stopwatch_counter_if.slave (control in, count/status out)
//  Params   : TICK_DIV - clk cycles per one-second step (>= 1)
//             MIN_MAX  - largest minutes value (1..255)
//  Config   : STOPWATCH_BCD_OUT_EN adds combinational sec_bcd/min_bcd
//             outputs (requires MIN_MAX <= 99).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stopwatch_counter #(
   parameter int TICK_DIV = 100_000_000,
   parameter int MIN_MAX  = 59
) (
   input  logic               clk,
   input  logic               rst,
   stopwatch_counter_if.slave bus
);

   localparam int MIN_W = $clog2(MIN_MAX + 1);
   // Keep the prescaler at least one bit wide so TICK_DIV=1 still elaborates.
   localparam int PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   localparam logic [PW-1:0]    c_presc_last = PW'(TICK_DIV - 1);
   localparam logic [MIN_W-1:0] c_min_max    = MIN_W'(MIN_MAX);
   localparam logic [5:0]       c_sec_max    = 6'd59;

   typedef enum logic [1:0] {
      RUN_IDLE  = 2'd0,
      RUN_COUNT = 2'd1,
      HALTED    = 2'd2
   } state_t;

   state_t           r_state,  w_state_nxt, w_run_state;
   logic [PW-1:0]    r_presc,  w_presc_nxt;
   logic [5:0]       r_sec,    w_sec_nxt;
   logic [MIN_W-1:0] r_min,    w_min_nxt;
   logic             r_tick,   w_tick_nxt;
   logic             r_term,   w_term_nxt;
   logic             w_ovf,    w_unf;

   // Boundary detection is evaluated against the direction in force at the
   // step, so a change of down between steps applies to the next step.
   assign w_ovf = !bus.down && (r_sec == c_sec_max) && (r_min == c_min_max);
   assign w_unf =  bus.down && (r_sec == 6'd0)      && (r_min == '0);

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= RUN_IDLE;
         r_presc <= '0;
         r_sec   <= '0;
         r_min   <= '0;
         r_tick  <= 1'b0;
         r_term  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_presc <= w_presc_nxt;
         r_sec   <= w_sec_nxt;
         r_min   <= w_min_nxt;
         r_tick  <= w_tick_nxt;
         r_term  <= w_term_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state / datapath: clear > load > step
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_presc_nxt = r_presc;
      w_sec_nxt   = r_sec;
      w_min_nxt   = r_min;
      w_tick_nxt  = 1'b0;
      w_term_nxt  = 1'b0;
      w_run_state = bus.enable ? RUN_COUNT : RUN_IDLE;

      if (bus.clear) begin
         w_sec_nxt   = '0;
         w_min_nxt   = '0;
         w_presc_nxt = '0;
         w_state_nxt = w_run_state;
      end else if (bus.load) begin
         w_sec_nxt   = (bus.load_sec > c_sec_max) ? c_sec_max : bus.load_sec;
         w_min_nxt   = (bus.load_min > c_min_max) ? c_min_max : bus.load_min;
         w_presc_nxt = '0;
         w_state_nxt = w_run_state;
      end else if (r_state != HALTED) begin
         w_state_nxt = w_run_state;
         if (bus.enable) begin
            if (r_presc != c_presc_last) begin
               w_presc_nxt = r_presc + PW'(1);
            end else begin
               w_presc_nxt = '0;
               if (w_ovf || w_unf) begin
                  if (bus.wrap_en) begin
                     // Wrapping lands on the opposite bound, which is never
                     // the terminal value for the current direction.
                     w_tick_nxt = 1'b1;
                     w_sec_nxt  = bus.down ? c_sec_max : 6'd0;
                     w_min_nxt  = bus.down ? c_min_max : '0;
                  end else begin
                     w_state_nxt = HALTED;
                  end
               end else if (!bus.down) begin
                  w_tick_nxt = 1'b1;
                  if (r_sec != c_sec_max) begin
                     w_sec_nxt = r_sec + 6'd1;
                  end else begin
                     w_sec_nxt = 6'd0;
                     w_min_nxt = r_min + MIN_W'(1);
                  end
                  w_term_nxt = (r_min == c_min_max) && (r_sec == 6'd58);
               end else begin
                  w_tick_nxt = 1'b1;
                  if (r_sec != 6'd0) begin
                     w_sec_nxt = r_sec - 6'd1;
                  end else begin
                     w_sec_nxt = c_sec_max;
                     w_min_nxt = r_min - MIN_W'(1);
                  end
                  w_term_nxt = (r_min == '0) && (r_sec == 6'd1);
               end
            end
         end
      end
   end

   assign bus.seconds  = r_sec;
   assign bus.minutes  = r_min;
   assign bus.tick     = r_tick;
   assign bus.terminal = r_term;
   assign bus.done     = (r_state == HALTED);

`ifdef STOPWATCH_BCD_OUT_EN
   // Two BCD digits cannot represent more than 99 minutes.
   generate
      if (MIN_MAX > 99) begin : g_bcd_range_err
         $error("stopwatch_counter: STOPWATCH_BCD_OUT_EN requires MIN_MAX <= 99");
      end
   endgenerate

   logic [7:0] w_sec8;
   logic [7:0] w_min8;

   assign w_sec8      = {2'b00, r_sec};
   assign w_min8      = 8'(r_min);
   assign bus.sec_bcd = {4'(w_sec8 / 8'd10), 4'(w_sec8 % 8'd10)};
   assign bus.min_bcd = {4'(w_min8 / 8'd10), 4'(w_min8 % 8'd10)};
`endif

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_counter.sv
// ============================================================================
//  Module   : tb_stopwatch_counter
//  Purpose  : Self-checking bench for stopwatch_counter (TICK_DIV=4,
//             MIN_MAX=9). A reference model tracks the count as a single
//             total-seconds integer plus a phase counter; directed steps
//             follow the stopwatch scenarios, then randomized traffic.
//  Config   : STOPWATCH_BCD_OUT_EN also checks the BCD outputs.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stopwatch_counter;

   localparam int TICK_DIV = 4;
   localparam int MIN_MAX  = 9;
   localparam int MIN_W    = 4;
   localparam int TOP      = MIN_MAX * 60 + 59;

   logic clk = 1'b0;
   logic rst = 1'b1;

   stopwatch_counter_if #(.MIN_W(MIN_W)) bus ();

   stopwatch_counter #(
      .TICK_DIV (TICK_DIV),
      .MIN_MAX  (MIN_MAX)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   int m_total;
   int m_phase;
   bit m_halted;
   bit m_tick;
   bit m_term;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      m_total  = 0;
      m_phase  = 0;
      m_halted = 1'b0;
      m_tick   = 1'b0;
      m_term   = 1'b0;
   endtask

   // One clock edge of the behavioural model, using the inputs held across it.
   task automatic m_edge();
      int ls, lm;
      m_tick = 1'b0;
      m_term = 1'b0;
      if (bus.clear) begin
         m_total = 0; m_phase = 0; m_halted = 1'b0;
      end else if (bus.load) begin
         ls = (int'(bus.load_sec) > 59) ? 59 : int'(bus.load_sec);
         lm = (int'(bus.load_min) > MIN_MAX) ? MIN_MAX : int'(bus.load_min);
         m_total = lm * 60 + ls; m_phase = 0; m_halted = 1'b0;
      end else if (bus.enable && !m_halted) begin
         if (m_phase == TICK_DIV - 1) begin
            m_phase = 0;
            if ((!bus.down && m_total == TOP) || (bus.down && m_total == 0)) begin
               if (bus.wrap_en) begin
                  m_total = bus.down ? TOP : 0;
                  m_tick  = 1'b1;
               end else begin
                  m_halted = 1'b1;
               end
            end else begin
               m_total = bus.down ? m_total - 1 : m_total + 1;
               m_tick  = 1'b1;
               m_term  = (m_total == (bus.down ? 0 : TOP));
            end
         end else begin
            m_phase++;
         end
      end
   endtask

   task automatic check_model(input string tag);
      chk({tag, "_sec"},  bus.seconds,  m_total % 60);
      chk({tag, "_min"},  bus.minutes,  m_total / 60);
      chk({tag, "_tick"}, bus.tick,     m_tick);
      chk({tag, "_term"}, bus.terminal, m_term);
      chk({tag, "_done"}, bus.done,     m_halted);
`ifdef STOPWATCH_BCD_OUT_EN
      chk({tag, "_sbcd"}, bus.sec_bcd, ((m_total % 60) / 10) * 16 + (m_total % 60) % 10);
      chk({tag, "_mbcd"}, bus.min_bcd, ((m_total / 60) / 10) * 16 + (m_total / 60) % 10);
`endif
   endtask

   task automatic cycle(input string tag);
      @(posedge clk);
      if (rst) m_reset();
      else     m_edge();
      #1;
      check_model(tag);
   endtask

   task automatic cycles(input int n, input string tag);
      for (int i = 0; i < n; i++) cycle(tag);
   endtask

   task automatic do_load(input int s, input int m);
      bus.load     = 1'b1;
      bus.load_sec = 6'(s);
      bus.load_min = MIN_W'(m);
      cycle("load");
      bus.load     = 1'b0;
   endtask

   initial begin
      bus.enable   = 1'b1;
      bus.down     = 1'b0;
      bus.wrap_en  = 1'b1;
      bus.clear    = 1'b0;
      bus.load     = 1'b0;
      bus.load_sec = '0;
      bus.load_min = '0;
      m_reset();

      // Reset state
      cycles(2, "rst");
      chk("rst_sec",  bus.seconds, 0);
      chk("rst_done", bus.done,    0);
      rst = 1'b0;

      // Up count with wrap: first tick four cycles after reset release
      cycles(3, "pre");
      chk("pre_tick", bus.tick, 0);
      cycle("first");
      chk("first_tick", bus.tick,    1);
      chk("first_sec",  bus.seconds, 1);
      cycles(598 * TICK_DIV, "up");
      chk("top_sec",  bus.seconds,  59);
      chk("top_min",  bus.minutes,  MIN_MAX);
      chk("top_term", bus.terminal, 1);
      cycles(TICK_DIV, "wrap");
      chk("wrap_sec",  bus.seconds,  0);
      chk("wrap_tick", bus.tick,     1);
      chk("wrap_term", bus.terminal, 0);

      // Down count with halt at 0:00
      bus.down    = 1'b1;
      bus.wrap_en = 1'b0;
      do_load(3, 0);
      cycles(3 * TICK_DIV, "down");
      chk("dn_term", bus.terminal, 1);
      chk("dn_sec",  bus.seconds,  0);
      cycles(TICK_DIV, "halt");
      chk("halt_done", bus.done, 1);
      chk("halt_tick", bus.tick, 0);
      bus.enable = 1'b0;
      cycles(5, "halt_off");
      bus.enable = 1'b1;
      bus.down   = 1'b0;
      cycles(8, "halt_on");
      chk("held_done", bus.done,    1);
      chk("held_sec",  bus.seconds, 0);
      do_load(0, 1);
      chk("reload_done", bus.done,    0);
      chk("reload_min",  bus.minutes, 1);

      // Pause preserves the partial second
      bus.wrap_en = 1'b1;
      cycles(2, "pp");
      bus.enable = 1'b0;
      cycles(50, "pause");
      bus.enable = 1'b1;
      cycle("resume1");
      chk("resume1_tick", bus.tick, 0);
      cycle("resume2");
      chk("resume2_tick", bus.tick,    1);
      chk("resume2_sec",  bus.seconds, 1);

      // Coincident clear + load + step
      cycles(TICK_DIV - 1, "align");
      bus.clear    = 1'b1;
      bus.load     = 1'b1;
      bus.load_sec = 6'd5;
      bus.load_min = 4'd2;
      cycle("clr_ld");
      bus.clear = 1'b0;
      bus.load  = 1'b0;
      chk("clr_sec",  bus.seconds, 0);
      chk("clr_min",  bus.minutes, 0);
      chk("clr_tick", bus.tick,    0);
      do_load(63, 12);
      chk("sat_sec", bus.seconds, 59);
      chk("sat_min", bus.minutes, 9);

      // Asynchronous reset mid-prescale at 3:27
      do_load(27, 3);
      cycles(2, "pre_arst");
      #2;
      rst = 1'b1;
      #1;
      m_reset();
      chk("arst_sec",  bus.seconds, 0);
      chk("arst_min",  bus.minutes, 0);
      chk("arst_tick", bus.tick,    0);
      chk("arst_done", bus.done,    0);
      cycles(2, "arst_hold");
      rst = 1'b0;
      cycles(TICK_DIV, "arst_resume");
      chk("arst_resume_tick", bus.tick, 1);

`ifdef STOPWATCH_BCD_OUT_EN
      bus.enable = 1'b0;
      do_load(37, 4);
      chk("bcd_sec", bus.sec_bcd, 32'h37);
      chk("bcd_min", bus.min_bcd, 32'h04);
      bus.enable = 1'b1;
`endif

      // Randomized traffic against the model
      for (int i = 0; i < 4000; i++) begin
         bus.enable  = ($urandom_range(7) != 0);
         if ($urandom_range(15) == 0) bus.down    = ~bus.down;
         if ($urandom_range(31) == 0) bus.wrap_en = ~bus.wrap_en;
         bus.clear    = ($urandom_range(127) == 0);
         bus.load     = ($urandom_range(47) == 0);
         bus.load_sec = 6'($urandom_range(63));
         bus.load_min = MIN_W'($urandom_range(15));
         cycle("rnd");
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
